// File: rtl/rvv_pkg.sv
// Shared encodings for the vector integer ALU: opcodes, operand types, SEW codes and FSM states.
package rvv_pkg;

  localparam logic [5:0] OP_VADD  = 6'b000000;
  localparam logic [5:0] OP_VSUB  = 6'b000010;
  localparam logic [5:0] OP_VRSUB = 6'b000011;
  localparam logic [5:0] OP_VAND  = 6'b001001;
  localparam logic [5:0] OP_VOR   = 6'b001010;
  localparam logic [5:0] OP_VXOR  = 6'b001011;

  localparam logic [2:0] OPT_VV = 3'b001;
  localparam logic [2:0] OPT_VX = 3'b010;
  localparam logic [2:0] OPT_VI = 3'b100;

  localparam logic [2:0] SEW_8  = 3'b000;
  localparam logic [2:0] SEW_16 = 3'b001;
  localparam logic [2:0] SEW_32 = 3'b010;
  localparam logic [2:0] SEW_64 = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_VADD, OP_VSUB, OP_VRSUB, OP_VAND, OP_VOR, OP_VXOR: op_legal = 1'b1;
      default:                                               op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rvv_alu_seq_if.sv
// Request/response bundle between the register-file read side and the sequenced vector ALU.
interface rvv_alu_seq_if #(
  parameter int unsigned VLEN = 128,
  parameter int unsigned VL_W = $clog2(VLEN / 8) + 1
);
  logic            start;
  logic [5:0]      opcode;
  logic [2:0]      op_type;
  logic [2:0]      vsew;
  logic [VL_W-1:0] vl;
  logic            vm;
  logic [VLEN-1:0] v0;
  logic [VLEN-1:0] vs1_in;
  logic [VLEN-1:0] vs2_in;
  logic [VLEN-1:0] vd_old;
  logic [63:0]     rs1;
  logic [4:0]      imm;
  logic            busy;
  logic            done;
  logic            illegal;
  logic [VLEN-1:0] vd;

  modport master (
    output start, opcode, op_type, vsew, vl, vm, v0, vs1_in, vs2_in, vd_old, rs1, imm,
    input  busy, done, illegal, vd
  );

  modport slave (
    input  start, opcode, op_type, vsew, vl, vm, v0, vs1_in, vs2_in, vd_old, rs1, imm,
    output busy, done, illegal, vd
  );
endinterface

// File: rtl/rvv_alu_lane.sv
// One CW-bit chunk slice: bitwise logic ops, or a ripple adder whose carry restarts at element starts.
module rvv_alu_lane
  import rvv_pkg::*;
#(
  parameter int unsigned CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic [5:0]    op,
  input  logic          cin,
  input  logic [CW-1:0] seg_start,
  output logic [CW-1:0] result,
  output logic          cout
);

  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          cin0;
  logic          c;

  always_comb begin
    x      = b;
    y      = a;
    cin0   = 1'b0;
    c      = cin;
    result = '0;
    // Subtractions are add-with-complement; carry-in of 1 completes the two's complement.
    case (op)
      OP_VSUB:  begin y = ~a; cin0 = 1'b1; end
      OP_VRSUB: begin x = a;  y = ~b; cin0 = 1'b1; end
      default:  ;
    endcase
    for (int k = 0; k < int'(CW); k++) begin
      if (seg_start[k]) c = cin0;
      case (op)
        OP_VAND: result[k] = a[k] & b[k];
        OP_VOR:  result[k] = a[k] | b[k];
        OP_VXOR: result[k] = a[k] ^ b[k];
        default: result[k] = x[k] ^ y[k] ^ c;
      endcase
      c = (x[k] & y[k]) | (c & (x[k] ^ y[k]));
    end
    cout = c;
  end

endmodule

// File: rtl/rvv_alu_seq.sv
// Multi-lane vector integer ALU: walks a VLEN-bit register CW*NL bits per cycle with
// masking, tail-undisturbed write-back and a carry register chaining wide elements across cycles.
module rvv_alu_seq
  import rvv_pkg::*;
#(
  parameter int unsigned VLEN          = 128,
  parameter int unsigned LANE_WIDTH    = 3,
  parameter int unsigned NB_LANES_LOG2 = 1,
  parameter int unsigned VL_W          = $clog2(VLEN / 8) + 1
) (
  input logic          clk,
  input logic          resetn,
  rvv_alu_seq_if.slave bus
);

  localparam int unsigned CW         = 1 << LANE_WIDTH;
  localparam int unsigned NL         = 1 << NB_LANES_LOG2;
  localparam int unsigned CHUNK_LOG2 = LANE_WIDTH + NB_LANES_LOG2;
  localparam int unsigned CHUNK      = 1 << CHUNK_LOG2;
  localparam int unsigned NCHUNK     = VLEN / CHUNK;
  localparam int unsigned PTR_W      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned IDX_W      = $clog2(VLEN);
  localparam int unsigned BITS_W     = IDX_W + 1;

  state_e             state_q;
  logic               busy_q, done_q, illegal_q, carry_q;
  logic [PTR_W-1:0]   ptr_q, last_q;
  logic [5:0]         op_q;
  logic [2:0]         sew_q;
  logic [VLEN-1:0]    a_q, b_q, wmask_q, vd_q;

  logic               bad_c;
  logic [2:0]         sew_log2_c;
  logic [5:0]         emask_c;
  logic [BITS_W-1:0]  max_el_c, vl_c, bits_c;
  logic [PTR_W-1:0]   last_c;
  logic [63:0]        scal_c;
  logic [VLEN-1:0]    a_c, wmask_c;
  logic [IDX_W-1:0]   elem_c;

  // Decode and pre-expand the request so RUN only slices latched vectors.
  always_comb begin
    bad_c      = !op_legal(bus.opcode) || (bus.vsew > SEW_64) ||
                 ((bus.op_type != OPT_VV) && (bus.op_type != OPT_VX) && (bus.op_type != OPT_VI));
    sew_log2_c = 3'(bus.vsew[1:0]) + 3'd3;
    emask_c    = 6'((7'd1 << sew_log2_c) - 7'd1);
    max_el_c   = BITS_W'(VLEN) >> sew_log2_c;
    vl_c       = (BITS_W'(bus.vl) > max_el_c) ? max_el_c : BITS_W'(bus.vl);
    bits_c     = vl_c << sew_log2_c;
    last_c     = PTR_W'((bits_c - BITS_W'(1)) >> CHUNK_LOG2);
    scal_c     = (bus.op_type == OPT_VX) ? bus.rs1 : {{59{bus.imm[4]}}, bus.imm};
    a_c        = '0;
    wmask_c    = '0;
    elem_c     = '0;
    for (int j = 0; j < int'(VLEN); j++) begin
      a_c[j]     = (bus.op_type == OPT_VV) ? bus.vs1_in[j] : scal_c[6'(j) & emask_c];
      elem_c     = IDX_W'(j) >> sew_log2_c;
      wmask_c[j] = (BITS_W'(elem_c) < vl_c) && (bus.vm || bus.v0[elem_c]);
    end
  end

  logic [IDX_W-1:0]  base_c, gidx_c, smask_c;
  logic [CHUNK-1:0]  a_ch, b_ch, m_ch, old_ch, seg_c, res_c;
  logic [NL:0]       carry_chain;

  always_comb begin
    base_c  = IDX_W'(ptr_q) << CHUNK_LOG2;
    smask_c = IDX_W'((32'd1 << sew_q) - 32'd1);
    a_ch    = a_q[base_c +: CHUNK];
    b_ch    = b_q[base_c +: CHUNK];
    m_ch    = wmask_q[base_c +: CHUNK];
    old_ch  = vd_q[base_c +: CHUNK];
    seg_c   = '0;
    gidx_c  = '0;
    for (int k = 0; k < int'(CHUNK); k++) begin
      gidx_c   = base_c + IDX_W'(k);
      seg_c[k] = ((gidx_c & smask_c) == '0);
    end
  end

  assign carry_chain[0] = carry_q;

  for (genvar l = 0; l < int'(NL); l++) begin : g_lane
    rvv_alu_lane #(.CW(CW)) u_lane (
      .a         (a_ch[l*CW +: CW]),
      .b         (b_ch[l*CW +: CW]),
      .op        (op_q),
      .cin       (carry_chain[l]),
      .seg_start (seg_c[l*CW +: CW]),
      .result    (res_c[l*CW +: CW]),
      .cout      (carry_chain[l+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      carry_q   <= 1'b0;
      ptr_q     <= '0;
      last_q    <= '0;
      op_q      <= '0;
      sew_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      wmask_q   <= '0;
      vd_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            op_q      <= bus.opcode;
            sew_q     <= sew_log2_c;
            a_q       <= a_c;
            b_q       <= bus.vs2_in;
            wmask_q   <= wmask_c;
            last_q    <= last_c;
            vd_q      <= bus.vd_old;
            ptr_q     <= '0;
            carry_q   <= 1'b0;
            illegal_q <= bad_c;
            if (bad_c || (vl_c == '0)) begin
              state_q <= ST_FIN;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          vd_q[base_c +: CHUNK] <= (res_c & m_ch) | (old_ch & ~m_ch);
          carry_q <= carry_chain[NL];
          ptr_q   <= ptr_q + PTR_W'(1);
          if (ptr_q == last_q) begin
            busy_q  <= 1'b0;
            state_q <= ST_FIN;
          end
        end
        ST_FIN: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.illegal = illegal_q;
  assign bus.vd      = vd_q;

endmodule

// File: tb/tb_rvv_alu_seq.sv
// Bench for rvv_alu_seq: directed cases plus random operations checked against an element-level model.
module tb_rvv_alu_seq;
  import rvv_pkg::*;

  localparam int unsigned VLEN  = 128;
  localparam int unsigned VL_W  = 5;
  localparam int unsigned CHUNK = 16;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  rvv_alu_seq_if #(.VLEN(VLEN), .VL_W(VL_W)) bus ();

  rvv_alu_seq #(
    .VLEN(VLEN), .LANE_WIDTH(3), .NB_LANES_LOG2(1), .VL_W(VL_W)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit ref_illegal(input logic [5:0] op, input logic [2:0] opt, input logic [2:0] sew);
    bit op_ok;
    op_ok = (op == 6'd0) || (op == 6'd2) || (op == 6'd3) || (op == 6'd9) || (op == 6'd10) || (op == 6'd11);
    return !op_ok || (sew > 3'd3) || !((opt == 3'b001) || (opt == 3'b010) || (opt == 3'b100));
  endfunction

  function automatic int ref_elems(input logic [2:0] sew, input logic [4:0] vl);
    int nel;
    nel = 128 / (8 << sew);
    return (int'(vl) > nel) ? nel : int'(vl);
  endfunction

  // Element-by-element reference: plain modular arithmetic on extracted elements.
  function automatic logic [127:0] ref_vd(input logic [5:0] op, input logic [2:0] opt, input logic [2:0] vsew,
                                          input logic [4:0] vl, input logic vm, input logic [127:0] v0,
                                          input logic [127:0] vs1, input logic [127:0] vs2,
                                          input logic [127:0] vdo, input logic [63:0] rs1, input logic [4:0] imm);
    int sew, vle;
    logic [63:0]  msk, a, b, r;
    logic [127:0] res, t;
    res = vdo;
    if (ref_illegal(op, opt, vsew)) return vdo;
    sew = 8 << vsew;
    vle = ref_elems(vsew, vl);
    msk = (sew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << sew) - 64'd1);
    for (int i = 0; i < vle; i++) begin
      if (!vm && !v0[i]) continue;
      t = vs2 >> (i * sew); b = t[63:0] & msk;
      t = vs1 >> (i * sew);
      if (opt == 3'b001)      a = t[63:0];
      else if (opt == 3'b010) a = rs1;
      else                    a = {{59{imm[4]}}, imm};
      a = a & msk;
      case (op)
        6'd0:    r = b + a;
        6'd2:    r = b - a;
        6'd3:    r = a - b;
        6'd9:    r = a & b;
        6'd10:   r = a | b;
        default: r = a ^ b;
      endcase
      r = r & msk;
      res = (res & ~({64'd0, msk} << (i * sew))) | ({64'd0, r} << (i * sew));
    end
    return res;
  endfunction

  task automatic run_op(input string tag, input logic [5:0] op, input logic [2:0] opt, input logic [2:0] vsew,
                        input logic [4:0] vl, input logic vm, input logic [127:0] v0,
                        input logic [127:0] vs1, input logic [127:0] vs2, input logic [127:0] vdo,
                        input logic [63:0] rs1, input logic [4:0] imm, input bit poke);
    logic [127:0] exp_vd;
    bit  exp_ill, seen;
    int  exp_run, lat, busy_n;
    exp_vd  = ref_vd(op, opt, vsew, vl, vm, v0, vs1, vs2, vdo, rs1, imm);
    exp_ill = ref_illegal(op, opt, vsew);
    exp_run = exp_ill ? 0 : (ref_elems(vsew, vl) * (8 << vsew) + CHUNK - 1) / CHUNK;

    @(negedge clk);
    bus.opcode = op;  bus.op_type = opt; bus.vsew = vsew; bus.vl = vl; bus.vm = vm;
    bus.v0 = v0; bus.vs1_in = vs1; bus.vs2_in = vs2; bus.vd_old = vdo; bus.rs1 = rs1; bus.imm = imm;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.vs1_in = rnd128(); bus.vs2_in = rnd128(); bus.vd_old = rnd128(); bus.v0 = rnd128();
    bus.rs1    = {$urandom, $urandom}; bus.imm = 5'($urandom); bus.vl = 5'($urandom);
    lat    = 1;
    busy_n = int'(bus.busy);
    seen   = bus.done;
    while (!seen && lat < 200) begin
      if (poke && lat == 2) begin
        bus.start = 1'b1; bus.opcode = 6'd11; bus.op_type = 3'b001; bus.vsew = 3'd0; bus.vl = 5'd16;
      end
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
      busy_n += int'(bus.busy);
      seen = bus.done;
    end
    check({tag, "_latency"}, 128'(lat), 128'(exp_run + 2));
    check({tag, "_busy_cycles"}, 128'(busy_n), 128'(exp_run));
    check({tag, "_illegal"}, 128'(bus.illegal), 128'(exp_ill));
    check({tag, "_vd"}, bus.vd, exp_vd);
    @(negedge clk);
    check({tag, "_done_pulse"}, 128'(bus.done), 128'(0));
    check({tag, "_vd_hold"}, bus.vd, exp_vd);
  endtask

  logic [5:0] ops [6] = '{6'd0, 6'd2, 6'd3, 6'd9, 6'd10, 6'd11};
  logic [2:0] opts[3] = '{3'b001, 3'b010, 3'b100};

  initial begin
    logic [127:0] vs1, vs2, vdo, expv;
    logic [5:0]   op;
    logic [2:0]   opt, sew;
    bit           seen;

    resetn = 1'b0;
    bus.start = 1'b0; bus.opcode = '0; bus.op_type = 3'b001; bus.vsew = '0; bus.vl = '0; bus.vm = 1'b1;
    bus.v0 = '0; bus.vs1_in = '0; bus.vs2_in = '0; bus.vd_old = '0; bus.rs1 = '0; bus.imm = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 128'(bus.busy), 128'(0));
    check("reset_done", 128'(bus.done), 128'(0));
    check("reset_illegal", 128'(bus.illegal), 128'(0));
    check("reset_vd", bus.vd, 128'(0));
    resetn = 1'b1;

    // vadd.vv SEW=32: no carry leaks from element 0 into element 1.
    vs2 = {64'd0, 32'h0001_0000, 32'hFFFF_FFFF};
    vs1 = {64'd0, 32'h0000_FFFF, 32'h0000_0001};
    run_op("vadd_vv", 6'd0, 3'b001, 3'd2, 5'd4, 1'b1, '0, vs1, vs2, rnd128(), '0, '0, 1'b0);
    expv = {64'd0, 64'h0001_FFFF_0000_0000};
    check("vadd_vv_const", bus.vd, expv);

    // vsub.vx SEW=8 with a start pulse while busy.
    for (int i = 0; i < 16; i++) vs2[i*8 +: 8] = 8'(i);
    run_op("vsub_vx", 6'd2, 3'b010, 3'd0, 5'd16, 1'b1, '0, rnd128(), vs2, rnd128(), 64'h1234_5605, '0, 1'b1);
    check("vsub_vx_byte0", 128'(bus.vd[7:0]), 128'(8'hFB));
    check("vsub_vx_byte5", 128'(bus.vd[47:40]), 128'(8'h00));

    run_op("vrsub_vi", 6'd3, 3'b100, 3'd1, 5'd8, 1'b1, '0, rnd128(), {8{16'h00FF}}, rnd128(), '0, 5'b11111, 1'b0);
    check("vrsub_vi_const", bus.vd, {8{16'hFF00}});

    run_op("vand_masked", 6'd9, 3'b001, 3'd0, 5'd10, 1'b0, 128'h5555, {16{8'h0F}}, {16{8'h0F}},
           {16{8'hAA}}, '0, '0, 1'b0);
    check("vand_masked_const", bus.vd, 128'hAAAAAAAAAAAA_AA0F_AA0F_AA0F_AA0F_AA0F);

    vdo = rnd128();
    run_op("vl_zero", 6'd0, 3'b001, 3'd0, 5'd0, 1'b1, '0, rnd128(), rnd128(), vdo, '0, '0, 1'b0);
    check("vl_zero_vd_old", bus.vd, vdo);
    vdo = rnd128();
    run_op("bad_opcode", 6'h3F, 3'b001, 3'd0, 5'd16, 1'b1, '0, rnd128(), rnd128(), vdo, '0, '0, 1'b0);
    check("bad_opcode_flag", 128'(bus.illegal), 128'(1));
    check("bad_opcode_vd_old", bus.vd, vdo);

    // Reset during the third RUN cycle aborts with no done pulse.
    @(negedge clk);
    bus.opcode = 6'd0; bus.op_type = 3'b001; bus.vsew = 3'd2; bus.vl = 5'd4; bus.vm = 1'b1;
    bus.vs1_in = rnd128(); bus.vs2_in = rnd128(); bus.vd_old = rnd128(); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_before", 128'(bus.busy), 128'(1));
    resetn = 1'b0;
    @(negedge clk);
    check("abort_busy", 128'(bus.busy), 128'(0));
    check("abort_done", 128'(bus.done), 128'(0));
    check("abort_vd", bus.vd, 128'(0));
    resetn = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("abort_no_done", 128'(seen), 128'(0));
    run_op("after_abort", 6'd0, 3'b001, 3'd3, 5'd2, 1'b1, '0, rnd128(), rnd128(), rnd128(), '0, '0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      op  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      opt = ($urandom_range(0, 9) == 0) ? 3'($urandom) : opts[$urandom_range(0, 2)];
      sew = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 3));
      run_op($sformatf("rand%0d", n), op, opt, sew, 5'($urandom), 1'($urandom), rnd128(),
             rnd128(), rnd128(), rnd128(), {$urandom, $urandom}, 5'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rvv_alu_seq.md
Name: rvv_alu_seq

Overview:
- Parametrised multi-lane vector integer ALU; successor to the single-chunk vector ALU.
- Processes a whole VLEN-bit vector register per operation.
- Each cycle, 2^NB_LANES_LOG2 lanes of CW = 2^LANE_WIDTH bits process consecutive chunks. Carries chain across lanes within a cycle and across cycles through a register.
- Adds a start/busy/done handshake, masking, tail-undisturbed policy, VX/VI operand broadcast and an illegal-op flag.
- Sits between the vector register file read ports and the write-back mux of the picorv32 vector extension.

Parameters:
- VLEN, 128, vector register width in bits (power of 2, 64..1024).
- LANE_WIDTH, 3, log2 of lane chunk width CW (3..6, so 8..64 bits).
- NB_LANES_LOG2, 1, log2 of lane count NL. Constraint: CW*NL <= VLEN.
- VL_W, $clog2(VLEN/8)+1, width of the vl port.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- start  in  1  request; sampled only in IDLE
- opcode  in  6  000000 vadd, 000010 vsub, 000011 vrsub, 001001 vand, 001010 vor, 001011 vxor
- op_type  in  3  001 VV, 010 VX, 100 VI (one-hot)
- vsew  in  3  000/001/010/011 = SEW 8/16/32/64
- vl  in  VL_W  element count
- vm  in  1  1 = unmasked
- v0  in  VLEN  mask register; bit i enables element i
- vs1_in, vs2_in, vd_old  in  VLEN  source operands and old destination value
- rs1  in  64  scalar operand for VX
- imm  in  5  immediate for VI
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse
- illegal  out  1  valid with done
- vd  out  VLEN  result; held stable from done until next start

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state becomes IDLE.
  - busy, done, illegal and vd are all 0.
  - Carry register and chunk pointer are 0.
  - Applies mid-operation too: the in-flight operation is aborted with no done pulse.
- FSM states: IDLE, RUN, FIN.
- IDLE, start=1:
  - Latch all inputs. Set vd <= vd_old, ptr <= 0.
  - If opcode is unsupported, vsew > 011, or op_type is not one-hot: illegal <= 1 and go to FIN.
  - Else if vl == 0: go to FIN.
  - Else: go to RUN.
- start in RUN or FIN is ignored. Inputs may change after the latch cycle.
- RUN: each cycle, process bits [ptr*CW*NL +: CW*NL] and set ptr <= ptr+1.
  - Go to FIN after the chunk holding bit vl*SEW-1.
  - Cycles in RUN = ceil(vl*SEW / (CW*NL)).
- FIN: done=1 for one cycle, then IDLE. Start-to-done latency = RUN cycles + 2.
- Operand a (vs1 side):
  - VV: vs1 element.
  - VX: rs1[SEW-1:0].
  - VI: imm sign-extended to SEW.
  - VX and VI are broadcast to every element.
- Operand b: vs2 element.
- Arithmetic (all modulo 2^SEW):
  - vadd: b + a, cin0 = 0.
  - vsub: b + ~a, cin0 = 1.
  - vrsub: a + ~b, cin0 = 1.
- Logic ops (vand, vor, vxor): bitwise, no carry.
- Carry rules:
  - Carry-in at each element's bit 0 is cin0.
  - Carry never crosses an element boundary.
  - If SEW < CW, a lane is segmented at SEW boundaries.
  - If SEW > CW, carry ripples lane-to-lane within a cycle. Carry out of the top lane is registered and used by the next cycle's lowest lane.
- Write policy for element i:
  - Written only if i < vl and (vm==1 or v0[i]==1).
  - Otherwise keeps its vd_old value (mask- and tail-undisturbed).
  - Whole elements only; an element is never partially written.
- Sizing: vl > VLEN/SEW is clamped to VLEN/SEW.

Decomposition:
- Shared package rvv_pkg holds:
  - opcode localparams (OP_VADD, OP_VSUB, OP_VRSUB, OP_VAND, OP_VOR, OP_VXOR);
  - op_type encodings VV/VX/VI;
  - SEW encodings;
  - the FSM state enum.
- Sub-module rvv_alu_lane, instantiated NL times. It is a CW-bit chunk slice with:
  - inputs: a, b, op, cin, and a per-bit segment-start vector (forces cin0 at element starts);
  - outputs: result and cout.

Test Plan:
- VLEN=128, CW=8, NL=2; vadd.vv, SEW=32, vl=4; vs2 e0=0xFFFFFFFF, e1=0x0001_0000; vs1 e0=1, e1=0x0000_FFFF -> e0=0, e1=0x0001_FFFF (no carry leaks from e0); busy for exactly 8 cycles; done on cycle 10.
- vsub.vx, SEW=8, vl=16, rs1=0x1234_5605, vs2 byte i = i -> byte i = (i-5) mod 256 (byte0=0xFB, byte5=0x00); illegal=0.
- vrsub.vi, imm=5'b11111, SEW=16, vl=8, vs2 halfwords=0x00FF -> all halfwords 0xFF00.
- vand.vv, vm=0, v0=0x5555, SEW=8, vl=10, vd_old=all 0xAA, vs1=vs2=all 0x0F -> bytes 0,2,4,6,8 = 0x0F; all others = 0xAA.
- vl=0 -> done two cycles after start, vd=vd_old. opcode 0x3F -> illegal=1 with done, vd=vd_old. start pulsed while busy -> no effect on the result.
- resetn=0 on the third RUN cycle -> next edge busy=0, done=0, vd=0, no done pulse. A fresh start then completes correctly.
